// File: rtl/secuenciador_mult_matriz.sv
// Sequencer for a 4x4 signed saturating matrix product C = A x B over one shared external multiplier.
// Optional macro SECUENCIADOR_PIPE_MUL_EN registers MulResult/MulError ahead of the accumulator.
//
// state | meaning
// IDLE  | host may load A/B; Start launches a run
// RUN   | one (i,j,k) product per cycle, k innermost
// DONE  | one-cycle completion pulse, then back to IDLE
module secuenciador_mult_matriz #(
    parameter int Width = 8,
    parameter int N     = 4,
    localparam int AddrW = 2 * $clog2(N)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             WrEn,
    input  logic             WrSel,
    input  logic [AddrW-1:0] WrAddr,
    input  logic [Width-1:0] WrData,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic             SatFlag,
    input  logic [AddrW-1:0] RdAddr,
    output logic [Width-1:0] RdData,
    output logic [Width-1:0] MulOpA,
    output logic [Width-1:0] MulOpB,
    input  logic [Width-1:0] MulResult,
    input  logic             MulError
);

    localparam int LW = $clog2(N);
    localparam logic [LW-1:0] IDX_MAX = LW'(N - 1);
    localparam logic signed [Width:0] SUM_MAX = (Width+1)'((1 << (Width - 1)) - 1);
    localparam logic signed [Width:0] SUM_MIN = -(Width+1)'(1 << (Width - 1));

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic signed [Width-1:0] a_mem [N*N];
    logic signed [Width-1:0] b_mem [N*N];
    logic signed [Width-1:0] c_mem [N*N];

    logic [LW-1:0] i_cnt, j_cnt, k_cnt;
    logic signed [Width-1:0] acc;

    logic last_step;
    logic issue;
    logic start_run;
    logic host_wr;

    logic signed [Width-1:0] prod;
    logic                    perr;
    logic                    pvalid;
    logic [LW-1:0]           pi, pj, pk;

    logic signed [Width:0]   sum;
    logic signed [Width-1:0] sum_clamp;
    logic                    clamped;

    assign last_step = (i_cnt == IDX_MAX) && (j_cnt == IDX_MAX) && (k_cnt == IDX_MAX);
    assign start_run = (state == IDLE) && Start;
    assign host_wr   = WrEn && (state != RUN);

`ifdef SECUENCIADOR_PIPE_MUL_EN
    logic signed [Width-1:0] mul_q;
    logic                    err_q;
    logic                    vld_q;
    logic                    drain;
    logic [LW-1:0]           i_q, j_q, k_q;

    // drain marks the extra RUN cycle that consumes the final registered product
    assign issue = (state == RUN) && !drain;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mul_q <= '0;
            err_q <= 1'b0;
            vld_q <= 1'b0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            drain <= 1'b0;
        end else begin
            mul_q <= MulResult;
            err_q <= MulError;
            vld_q <= issue;
            i_q   <= i_cnt;
            j_q   <= j_cnt;
            k_q   <= k_cnt;
            if (issue && last_step)
                drain <= 1'b1;
            else if (state != RUN)
                drain <= 1'b0;
        end
    end

    assign prod   = mul_q;
    assign perr   = err_q;
    assign pvalid = vld_q;
    assign pi     = i_q;
    assign pj     = j_q;
    assign pk     = k_q;
`else
    assign issue  = (state == RUN);
    assign prod   = MulResult;
    assign perr   = MulError;
    assign pvalid = issue;
    assign pi     = i_cnt;
    assign pj     = j_cnt;
    assign pk     = k_cnt;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        MulOpA    = '0;
        MulOpB    = '0;
        case (state)
            IDLE: begin
                if (Start)
                    state_nxt = RUN;
            end
            RUN: begin
                Busy = 1'b1;
`ifdef SECUENCIADOR_PIPE_MUL_EN
                if (drain)
                    state_nxt = DONE;
`else
                if (last_step)
                    state_nxt = DONE;
`endif
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (issue) begin
            MulOpA = a_mem[{i_cnt, k_cnt}];
            MulOpB = b_mem[{k_cnt, j_cnt}];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
        end else if (start_run) begin
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
        end else if (issue) begin
            k_cnt <= k_cnt + 1'b1;
            if (k_cnt == IDX_MAX) begin
                j_cnt <= j_cnt + 1'b1;
                if (j_cnt == IDX_MAX)
                    i_cnt <= i_cnt + 1'b1;
            end
        end
    end

    // Width+1 bits cannot overflow; bits [Width:Width-1] disagreeing means out of range
    always_comb begin
        sum       = {acc[Width-1], acc} + {prod[Width-1], prod};
        clamped   = 1'b0;
        sum_clamp = sum[Width-1:0];
        if (sum > SUM_MAX) begin
            clamped   = 1'b1;
            sum_clamp = SUM_MAX[Width-1:0];
        end else if (sum < SUM_MIN) begin
            clamped   = 1'b1;
            sum_clamp = SUM_MIN[Width-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc     <= '0;
            SatFlag <= 1'b0;
        end else if (start_run) begin
            acc     <= '0;
            SatFlag <= 1'b0;
        end else if (pvalid) begin
            if (pk == IDX_MAX)
                acc <= '0;
            else
                acc <= sum_clamp;
            if (perr || clamped)
                SatFlag <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int e = 0; e < N*N; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
            end
        end else if (host_wr) begin
            if (WrSel)
                b_mem[WrAddr] <= WrData;
            else
                a_mem[WrAddr] <= WrData;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int e = 0; e < N*N; e++)
                c_mem[e] <= '0;
        end else if (pvalid && (pk == IDX_MAX)) begin
            c_mem[{pi, pj}] <= sum_clamp;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            RdData <= '0;
        else
            RdData <= c_mem[RdAddr];
    end

endmodule

// File: tb/tb_secuenciador_mult_matriz.sv
// Directed bench for secuenciador_mult_matriz with a behavioural saturating multiplier.
module tb_secuenciador_mult_matriz;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       WrEn = 1'b0;
    logic       WrSel = 1'b0;
    logic [3:0] WrAddr = '0;
    logic [7:0] WrData = '0;
    logic       Start = 1'b0;
    logic       Busy, Done, SatFlag;
    logic [3:0] RdAddr = '0;
    logic [7:0] RdData;
    logic [7:0] MulOpA, MulOpB;
    logic [7:0] MulResult;
    logic       MulError;

`ifdef SECUENCIADOR_PIPE_MUL_EN
    localparam int RUN_LEN = 65;
`else
    localparam int RUN_LEN = 64;
`endif

    int checks = 0;
    int failures = 0;
    int busy_cnt, done_at;
    logic [7:0] opa1, opb1;

    secuenciador_mult_matriz #(.Width(8), .N(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .WrEn(WrEn), .WrSel(WrSel), .WrAddr(WrAddr),
        .WrData(WrData), .Start(Start), .Busy(Busy), .Done(Done), .SatFlag(SatFlag),
        .RdAddr(RdAddr), .RdData(RdData), .MulOpA(MulOpA), .MulOpB(MulOpB),
        .MulResult(MulResult), .MulError(MulError)
    );

    always #5 Clk = ~Clk;

    // external Multiplicador: combinational signed product saturated to 8 bits
    logic signed [15:0] full_p;
    always_comb begin
        full_p    = $signed(MulOpA) * $signed(MulOpB);
        MulError  = 1'b0;
        MulResult = full_p[7:0];
        if (full_p > 16'sd127) begin
            MulResult = 8'h7f;
            MulError  = 1'b1;
        end else if (full_p < -16'sd128) begin
            MulResult = 8'h80;
            MulError  = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input int addr, input int data);
        @(negedge Clk);
        WrEn   = 1'b1;
        WrSel  = sel;
        WrAddr = 4'(addr);
        WrData = 8'(data);
        @(negedge Clk);
        WrEn   = 1'b0;
    endtask

    task automatic fill(input logic sel, input int data);
        for (int e = 0; e < 16; e++) wr(sel, e, data);
    endtask

    task automatic read_c(input int addr, output logic signed [7:0] val);
        @(negedge Clk);
        RdAddr = 4'(addr);
        @(negedge Clk);
        val = RdData;
    endtask

    task automatic check_c_all(input string tag, input int exp);
        logic signed [7:0] v;
        for (int e = 0; e < 16; e++) begin
            read_c(e, v);
            chk(tag, v, exp);
        end
    endtask

    // Start launches at the posedge after this negedge (t0); sample index n is cycle t0+n
    task automatic run(input bit disturb, input bit wr_now, input int wr_val);
        @(negedge Clk);
        Start = 1'b1;
        if (wr_now) begin
            WrEn = 1'b1; WrSel = 1'b0; WrAddr = 4'd0; WrData = 8'(wr_val);
        end
        @(negedge Clk);
        Start = 1'b0;
        WrEn  = 1'b0;
        busy_cnt = 0;
        done_at  = 0;
        for (int n = 1; n <= 200; n++) begin
            if (n > 1) @(negedge Clk);
            if (n == 1) begin
                opa1 = MulOpA;
                opb1 = MulOpB;
            end
            if (Busy) busy_cnt++;
            if (Done) begin
                done_at = n;
                break;
            end
            Start = 1'b0;
            WrEn  = 1'b0;
            if (disturb && n == 10) begin
                Start = 1'b1; WrEn = 1'b1; WrSel = 1'b0; WrAddr = 4'd0; WrData = 8'd5;
            end else if (disturb && n == 11) begin
                Start = 1'b1; WrEn = 1'b1; WrSel = 1'b1; WrAddr = 4'd0; WrData = 8'd5;
            end
        end
        Start = 1'b0;
        WrEn  = 1'b0;
        chk("done_at", done_at, RUN_LEN + 1);
        chk("busy_cycles", busy_cnt, RUN_LEN);
        @(negedge Clk);
        chk("done_one_cycle", Done, 0);
        chk("busy_after_done", Busy, 0);
    endtask

    initial begin
        logic signed [7:0] v;

        #12;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_sat", SatFlag, 0);
        chk("rst_rddata", RdData, 0);
        chk("rst_opa", MulOpA, 0);
        chk("rst_opb", MulOpB, 0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // identity: C must equal B
        for (int e = 0; e < 16; e++) wr(1'b0, e, (e / 4 == e % 4) ? 1 : 0);
        for (int e = 0; e < 16; e++) wr(1'b1, e, e - 8);
        run(1'b0, 1'b0, 0);
        chk("id_opa_first", $signed(opa1), 1);
        chk("id_opb_first", $signed(opb1), -8);
        chk("id_sat", SatFlag, 0);
        chk("idle_opa", MulOpA, 0);
        for (int e = 0; e < 16; e++) begin
            read_c(e, v);
            chk("id_c", v, e - 8);
        end

        fill(1'b0, 2);
        fill(1'b1, 2);
        run(1'b0, 1'b0, 0);
        chk("twos_sat", SatFlag, 0);
        check_c_all("twos_c", 16);

        fill(1'b0, 100);
        run(1'b0, 1'b0, 0);
        chk("possat_flag", SatFlag, 1);
        check_c_all("possat_c", 127);

        fill(1'b0, -100);
        run(1'b0, 1'b0, 0);
        chk("negsat_flag", SatFlag, 1);
        check_c_all("negsat_c", -128);

        fill(1'b0, 10);
        fill(1'b1, 10);
        run(1'b0, 1'b0, 0);
        chk("accsat_flag", SatFlag, 1);
        check_c_all("accsat_c", 127);

        // writes and Start during Busy are ignored
        fill(1'b0, 1);
        fill(1'b1, 1);
        run(1'b1, 1'b0, 0);
        chk("prot_sat_cleared", SatFlag, 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge Clk);
            chk("prot_no_rerun", Busy, 0);
        end
        check_c_all("prot_c", 4);

        // Start with a same-edge write to A[0][0]
        run(1'b0, 1'b1, 3);
        for (int e = 0; e < 16; e++) begin
            read_c(e, v);
            chk("startwr_c", v, (e < 4) ? 6 : 4);
        end

        // reset mid-run
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (19) @(negedge Clk);
        chk("midrun_busy_before", Busy, 1);
        Rst_n = 1'b0;
        #1;
        chk("midrun_busy", Busy, 0);
        chk("midrun_done", Done, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        check_c_all("midrun_c_zero", 0);
        fill(1'b0, 2);
        fill(1'b1, 2);
        run(1'b0, 1'b0, 0);
        check_c_all("after_rst_c", 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/secuenciador_mult_matriz.md
Name: secuenciador_mult_matriz

Overview:
- Sequences a 4x4 signed saturating matrix product C = A x B over one shared external Multiplicador instance. That instance is combinational, Width-bit signed, and saturates with an Error flag.
- Holds the A, B and C register files and time-multiplexes the multiplier, one product per cycle.
- Accumulates each dot product with a saturating adder.
- Sits between the host load/read interface and the multiplier datapath.

Parameters:
- Width, 8, signed element width; must equal the Width of the attached Multiplicador.
- N, 4, matrix dimension; power of two. Derived localparam AddrW = 2*log2(N).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- WrEn  in  1  write one element of A or B.
- WrSel  in  1  0 selects A, 1 selects B.
- WrAddr  in  AddrW  element index, row*N+col.
- WrData  in  Width  signed element value.
- Start  in  1  start-run request, sampled in IDLE.
- Busy  out  1  run in progress.
- Done  out  1  one-cycle pulse at end of run.
- SatFlag  out  1  sticky; set if any saturation occurred in the last run.
- RdAddr  in  AddrW  C element index, row*N+col.
- RdData  out  Width  C[RdAddr], registered.
- MulOpA  out  Width  operand A to the multiplier.
- MulOpB  out  Width  operand B to the multiplier.
- MulResult  in  Width  saturated product from the multiplier.
- MulError  in  1  multiplier saturation flag.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - State = IDLE.
  - Busy, Done, SatFlag, RdData, MulOpA, MulOpB = 0.
  - A, B, C arrays, accumulator and i/j/k counters = 0.
- Reset mid-run aborts immediately; C is left all-zero.
- FSM states:
  - IDLE: Start=1 -> RUN; clear i, j, k, accumulator and SatFlag.
  - RUN: Busy=1; one (i,j,k) step per cycle, k innermost, then j, then i.
  - DONE: Busy=0, Done=1 for exactly one cycle, then -> IDLE.
- Timing: Start sampled at edge t0. Busy is high for cycles t0+1 .. t0+N^3 (64 cycles). Done is high in cycle t0+N^3+1.
- RUN step (all within one cycle):
  - MulOpA = A[i][k] and MulOpB = B[k][j], combinational from the counters.
  - sum = acc + MulResult, computed at Width+1 bits, then clamped to [-2^(Width-1), 2^(Width-1)-1].
  - If k < N-1: acc <= clamped sum.
  - If k == N-1: C[i][j] <= clamped sum and acc <= 0.
  - SatFlag <= 1 if MulError=1 or the clamp was active.
- Counter wrap: when k==N-1 and j==N-1 and i==N-1, go to DONE; counters wrap to 0.
- Outside RUN, MulOpA and MulOpB are held at 0.
- Writes:
  - Accepted only in IDLE and DONE; ignored while Busy=1, so A and B stay frozen during a run.
  - WrEn together with Start in IDLE: the write commits at the same edge, and the run uses the updated value.
- Start while Busy=1 or in DONE: ignored, no queuing.
- Read: RdData <= C[RdAddr] every cycle, 1-cycle latency. Reads during a run return partial or previous C contents; this is legal.
- Sign handling: all arithmetic is two's complement signed; MulResult is sign-extended to Width+1 bits before the add.

Optional Feature:
- Macro: SECUENCIADOR_PIPE_MUL_EN.
- Defined:
  - MulResult and MulError are registered before the adder, adding one pipeline stage.
  - The run takes N^3+1 cycles; Done is high in cycle t0+N^3+2.
  - The adder consumes the step-(n-1) product in step n, with the k==N-1 write-back delayed accordingly.
  - The first RUN cycle adds nothing.
- Undefined: combinational path exactly as described in Behaviour.

Test Plan:
- Identity: A = I, B[r][c] = r*4+c-8; Start -> Done at t0+65, C == B, SatFlag=0.
- All 2s: A and B all 2 -> every C element = 16, SatFlag=0, Busy high for exactly 64 cycles.
- Positive saturation: A all 100, B all 2; multiplier returns 127 with MulError=1 -> every C = 127, SatFlag=1.
- Negative saturation: A all -100, B all 2 -> every C = -128, SatFlag=1. Separately, A all 10, B all 10 -> each product 100, accumulator clamps at 127, SatFlag=1.
- Protocol: Start pulses and WrEn writes during Busy are ignored (A/B unchanged, no second run). Start+WrEn on the same IDLE edge -> the run uses the new element.
- Reset mid-run: deassert Rst_n at cycle t0+20 -> Busy=0, Done=0 immediately. After release, reading all RdAddr returns 0 and a new Start completes normally.
